// File: rtl/accel_fifo_if.sv
// ============================================================================
//  Module      : accel_fifo_if
//  Description : Producer/consumer bus of the accelerator FIFO. The master
//                side drives the put/get requests and write data. The slave
//                side (the FIFO) returns read data, status and sticky error
//                flags. Optional almost flags exist when ACCEL_FIFO_ALMOST_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accel_fifo_if #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             put_req;
   logic [WIDTH-1:0] data_in;
   logic             get_req;
   logic [WIDTH-1:0] data_out;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;
`ifdef ACCEL_FIFO_ALMOST_EN
   logic             almost_full;
   logic             almost_empty;

   modport master (
      output put_req, data_in, get_req,
      input  data_out, empty, full, count, overflow, underflow,
             almost_full, almost_empty
   );

   modport slave (
      input  put_req, data_in, get_req,
      output data_out, empty, full, count, overflow, underflow,
             almost_full, almost_empty
   );
`else
   modport master (
      output put_req, data_in, get_req,
      input  data_out, empty, full, count, overflow, underflow
   );

   modport slave (
      input  put_req, data_in, get_req,
      output data_out, empty, full, count, overflow, underflow
   );
`endif

endinterface

`default_nettype wire

// File: rtl/accel_fifo.sv
// ============================================================================
//  Module      : accel_fifo
//  Description : Single-clock synchronous FIFO between a data bus controller
//                and an accelerator. Registered read data (one cycle latency),
//                occupancy counter, and sticky overflow/underflow flags.
//                When full, a simultaneous put and get are both accepted. When
//                empty, a simultaneous put and get accept only the put.
//                Define ACCEL_FIFO_ALMOST_EN to add almost_full/almost_empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_fifo #(
   parameter int WIDTH         = 128,
   parameter int DEPTH         = 16,
   parameter int ALMOST_THRESH = 2
) (
   input  wire          clk,
   input  wire          reset,
   accel_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   // Reject parameter sets the pointer arithmetic cannot support
   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("accel_fifo: DEPTH must be a power of two and at least 4");
   end
   if ((ALMOST_THRESH < 0) || (ALMOST_THRESH > DEPTH)) begin : g_bad_thresh
      $error("accel_fifo: ALMOST_THRESH must lie in 0..DEPTH");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occupancy;
   logic [WIDTH-1:0] rd_data;
   logic             overflow_flag;
   logic             underflow_flag;

   logic             is_empty;
   logic             is_full;
   logic             rd_fire;
   logic             wr_fire;

   // Status comes only from the registered occupancy
   assign is_empty = (occupancy == '0);
   assign is_full  = (occupancy == (AW+1)'(DEPTH));

   // A get needs data; a put needs room, or a concurrent get freeing a slot
   assign rd_fire = bus.get_req && !is_empty;
   assign wr_fire = bus.put_req && (!is_full || rd_fire);

   // Storage array: written on accepted puts, never reset
   always_ff @(posedge clk) begin
      if (!reset && wr_fire) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   // Pointers, occupancy, read data register and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         occupancy      <= '0;
         rd_data        <= '0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_fire) begin
            // Old array contents are read, so a put landing in the freed
            // slot on this same edge cannot disturb the word being read
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         if (wr_fire && !rd_fire) begin
            occupancy <= occupancy + 1'b1;
         end else if (rd_fire && !wr_fire) begin
            occupancy <= occupancy - 1'b1;
         end
         if (bus.put_req && !wr_fire) begin
            overflow_flag <= 1'b1;
         end
         if (bus.get_req && !rd_fire) begin
            underflow_flag <= 1'b1;
         end
      end
   end

   assign bus.data_out  = rd_data;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.count     = occupancy;
   assign bus.overflow  = overflow_flag;
   assign bus.underflow = underflow_flag;

`ifdef ACCEL_FIFO_ALMOST_EN
   localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - ALMOST_THRESH);
   localparam logic [AW:0] AE_LEVEL = (AW+1)'(ALMOST_THRESH);

   assign bus.almost_full  = (occupancy >= AF_LEVEL);
   assign bus.almost_empty = (occupancy <= AE_LEVEL);
`endif

endmodule

`default_nettype wire

// File: tb/tb_accel_fifo.sv
// ============================================================================
//  Module      : tb_accel_fifo
//  Description : Directed self-checking bench for accel_fifo: reset, fill and
//                drain, overflow, simultaneous put/get at full and empty,
//                pointer wrap against a queue model, mid-operation reset and
//                (when ACCEL_FIFO_ALMOST_EN is defined) the almost flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_fifo;

   localparam int WIDTH = 128;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] exp_word;

   accel_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   accel_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .ALMOST_THRESH(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      bus.put_req = 1'b0;
      bus.get_req = 1'b0;
      bus.data_in = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_empty",     bus.empty,     1);
      check("rst_full",      bus.full,      0);
      check("rst_count",     bus.count,     0);
      check("rst_data_out",  bus.data_out,  0);
      check("rst_overflow",  bus.overflow,  0);
      check("rst_underflow", bus.underflow, 0);
`ifdef ACCEL_FIFO_ALMOST_EN
      check("rst_almost_full",  bus.almost_full,  0);
      check("rst_almost_empty", bus.almost_empty, 1);
`endif

      // Fill with 0x1..0x10
      for (int i = 1; i <= DEPTH; i++) begin
         bus.put_req = 1'b1;
         bus.data_in = WIDTH'(i);
         step();
         check("fill_count", bus.count, i);
`ifdef ACCEL_FIFO_ALMOST_EN
         if (i == 2)  check("ae_at_2",  bus.almost_empty, 1);
         if (i == 3)  check("ae_at_3",  bus.almost_empty, 0);
         if (i == 13) check("af_at_13", bus.almost_full,  0);
         if (i == 14) check("af_at_14", bus.almost_full,  1);
`endif
      end
      bus.put_req = 1'b0;
      check("fill_full",  bus.full,  1);
      check("fill_empty", bus.empty, 0);

      // Overflow: put while full, no get
      bus.put_req = 1'b1;
      bus.data_in = WIDTH'(32'hDEAD);
      step();
      bus.put_req = 1'b0;
      check("ovf_flag",  bus.overflow, 1);
      check("ovf_count", bus.count,    16);
      check("ovf_full",  bus.full,     1);
      check("ovf_data",  bus.data_out, 0);

      // Drain: data one cycle after each get, in order, 0xDEAD never appears
      for (int i = 1; i <= DEPTH; i++) begin
         bus.get_req = 1'b1;
         step();
         check("drain_data", bus.data_out, WIDTH'(i));
      end
      bus.get_req = 1'b0;
      check("drain_empty",     bus.empty,     1);
      check("drain_count",     bus.count,     0);
      check("ovf_sticky",      bus.overflow,  1);
      check("drain_underflow", bus.underflow, 0);
      step();
      check("hold_data", bus.data_out, WIDTH'(16));

      // Refill with 0x100..0x10F, then put 0xBEEF with a get while full
      for (int i = 0; i < DEPTH; i++) begin
         bus.put_req = 1'b1;
         bus.data_in = WIDTH'(32'h100 + i);
         step();
      end
      bus.data_in = WIDTH'(32'hBEEF);
      bus.get_req = 1'b1;
      step();
      bus.put_req = 1'b0;
      bus.get_req = 1'b0;
      check("full_both_data",  bus.data_out, WIDTH'(32'h100));
      check("full_both_count", bus.count,    16);
      check("full_both_full",  bus.full,     1);
      for (int i = 1; i <= DEPTH; i++) begin
         bus.get_req = 1'b1;
         step();
         exp_word = (i == DEPTH) ? WIDTH'(32'hBEEF) : WIDTH'(32'h100 + i);
         check("full_both_drain", bus.data_out, exp_word);
      end
      bus.get_req = 1'b0;
      check("full_both_empty", bus.empty,     1);
      check("no_underflow",    bus.underflow, 0);

      // Put and get together while empty: only the put is accepted
      bus.put_req = 1'b1;
      bus.get_req = 1'b1;
      bus.data_in = WIDTH'(32'h55);
      step();
      bus.put_req = 1'b0;
      check("empty_both_count", bus.count,     1);
      check("empty_both_unf",   bus.underflow, 1);
      check("empty_both_data",  bus.data_out,  WIDTH'(32'hBEEF));
      step();
      bus.get_req = 1'b0;
      check("empty_both_read",  bus.data_out,  WIDTH'(32'h55));
      check("empty_both_cnt0",  bus.count,     0);
      check("unf_sticky",       bus.underflow, 1);

      // Wrap-around: preload 8 words, then 40 interleaved cycles near count 8
      for (int k = 0; k < 8; k++) begin
         bus.put_req = 1'b1;
         bus.data_in = WIDTH'(32'h2000 + k);
         model_q.push_back(WIDTH'(32'h2000 + k));
         step();
      end
      bus.put_req = 1'b0;
      check("wrap_preload", bus.count, 8);
      for (int k = 0; k < 40; k++) begin
         bus.put_req = ((k % 4) != 2);
         bus.get_req = ((k % 4) != 1);
         bus.data_in = WIDTH'(32'h3000 + k);
         exp_word = '0;
         if (bus.get_req) exp_word = model_q.pop_front();
         if (bus.put_req) model_q.push_back(WIDTH'(32'h3000 + k));
         step();
         if ((k % 4) != 1) check("wrap_data", bus.data_out, exp_word);
      end
      bus.put_req = 1'b0;
      bus.get_req = 1'b0;
      check("wrap_count", bus.count, WIDTH'(model_q.size()));

      // Drop to count 5, then reset with both requests active
      for (int k = 0; k < 3; k++) begin
         bus.get_req = 1'b1;
         exp_word = model_q.pop_front();
         step();
         check("pre_rst_data", bus.data_out, exp_word);
      end
      check("pre_rst_count", bus.count, 5);
      reset       = 1'b1;
      bus.put_req = 1'b1;
      bus.get_req = 1'b1;
      bus.data_in = WIDTH'(32'h77);
      step();
      reset       = 1'b0;
      bus.put_req = 1'b0;
      bus.get_req = 1'b0;
      check("mid_rst_count", bus.count,     0);
      check("mid_rst_empty", bus.empty,     1);
      check("mid_rst_data",  bus.data_out,  0);
      check("mid_rst_ovf",   bus.overflow,  0);
      check("mid_rst_unf",   bus.underflow, 0);
`ifdef ACCEL_FIFO_ALMOST_EN
      check("mid_rst_ae", bus.almost_empty, 1);
      check("mid_rst_af", bus.almost_full,  0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
